operand_dispatcher: RTL and testbench

OPERAND_DISPATCHER -- requirements
Module: operand_dispatcher

---
 rtl/operand_dispatcher.sv | 155 +++++++++++++++
 tb/tb_operand_dispatcher.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_dispatcher.sv
// Operand-tuple queue feeding a downstream polynomial block: FIFO, issue FSM, result capture.
// Optional watchdog on WAIT_VALID, enabled by defining OPERAND_DISPATCHER_TIMEOUT_EN.
module operand_dispatcher #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               push,
   input  logic signed [7:0]  x_in,
   input  logic signed [15:0] a_in,
   input  logic signed [15:0] b_in,
   input  logic signed [15:0] c_in,
   output logic               full,
   output logic               empty,
   output logic               overflow,
   output logic signed [7:0]  x,
   output logic signed [15:0] a,
   output logic signed [15:0] b,
   output logic signed [15:0] c,
   output logic               enable,
   input  logic               ready,
   input  logic               valid,
   input  logic signed [15:0] y,
   output logic signed [15:0] y_out,
   output logic               y_strobe,
   output logic               error
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_VALID, WAIT_READY} state_t;

   logic [55:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [PW:0]   count_reg;
   logic [55:0]   head;
   logic          push_ok;
   logic          pop;
   state_t        state_reg;
   logic          valid_prev_reg;
   logic          valid_edge;
   logic          timeout_hit;

   assign full       = (count_reg == (PW+1)'(DEPTH));
   assign empty      = (count_reg == '0);
   assign push_ok    = push && !full;
   assign pop        = (state_reg == IDLE) && !empty && ready;
   assign head       = mem[rd_ptr_reg];
   assign valid_edge = valid && !valid_prev_reg;

   always_ff @(posedge clock) begin
      if (push_ok)
         mem[wr_ptr_reg] <= {x_in, a_in, b_in, c_in};
   end

   // A push into a full queue is dropped even when a pop frees a slot this cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push && full)
            overflow <= 1'b1;
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         case ({push_ok, pop})
            2'b10:   count_reg <= count_reg + (PW+1)'(1);
            2'b01:   count_reg <= count_reg - (PW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= IDLE;
         x              <= '0;
         a              <= '0;
         b              <= '0;
         c              <= '0;
         enable         <= 1'b0;
         y_out          <= '0;
         y_strobe       <= 1'b0;
         valid_prev_reg <= 1'b0;
      end else begin
         valid_prev_reg <= valid;
         enable         <= 1'b0;
         y_strobe       <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (pop) begin
                  x         <= head[55:48];
                  a         <= head[47:32];
                  b         <= head[31:16];
                  c         <= head[15:0];
                  enable    <= 1'b1;
                  state_reg <= ISSUE;
               end
            end
            ISSUE: state_reg <= WAIT_VALID;
            WAIT_VALID: begin
               // Only a fresh rising edge counts; a level left over from the last result is ignored.
               if (valid_edge) begin
                  y_out     <= y;
                  y_strobe  <= 1'b1;
                  state_reg <= WAIT_READY;
               end else if (timeout_hit) begin
                  state_reg <= IDLE;
               end
            end
            WAIT_READY: begin
               if (ready)
                  state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef OPERAND_DISPATCHER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] wd_cnt_reg;

   assign timeout_hit = (state_reg == WAIT_VALID) && !valid_edge &&
                        (wd_cnt_reg == TW'(TIMEOUT - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         wd_cnt_reg <= '0;
         error      <= 1'b0;
      end else begin
         if (state_reg != WAIT_VALID || timeout_hit)
            wd_cnt_reg <= '0;
         else
            wd_cnt_reg <= wd_cnt_reg + TW'(1);
         if (timeout_hit)
            error <= 1'b1;
      end
   end
`else
   logic unused_timeout;

   assign unused_timeout = ^TIMEOUT;
   assign timeout_hit    = 1'b0;
   assign error          = 1'b0;
`endif

endmodule

// File: tb/tb_operand_dispatcher.sv
// Directed bench for operand_dispatcher with a 3-cycle polynomial downstream model.
module tb_operand_dispatcher;

   typedef struct {
      logic signed [7:0]  x;
      logic signed [15:0] a;
      logic signed [15:0] b;
      logic signed [15:0] c;
      logic signed [15:0] y;
   } vec_t;

   vec_t vecs [5];
   int   checks = 0;
   int   errors = 0;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic               push = 1'b0;
   logic signed [7:0]  x_in = '0;
   logic signed [15:0] a_in = '0, b_in = '0, c_in = '0;
   logic               full, empty, overflow, enable, y_strobe, error;
   logic signed [7:0]  x;
   logic signed [15:0] a, b, c, y_out;
   logic               ready;
   logic               valid = 1'b0;
   logic signed [15:0] y = '0;

   logic               model_ready = 1'b1;
   logic               hold = 1'b0;
   logic               mute = 1'b0;
   logic               busy = 1'b0;
   int                 cnt = 0;
   logic signed [15:0] ry = '0;

   assign ready = model_ready & ~hold;

   always #5 clock = ~clock;

   operand_dispatcher #(.DEPTH(4), .TIMEOUT(10)) dut (
      .clock(clock), .reset(reset), .push(push),
      .x_in(x_in), .a_in(a_in), .b_in(b_in), .c_in(c_in),
      .full(full), .empty(empty), .overflow(overflow),
      .x(x), .a(a), .b(b), .c(c), .enable(enable),
      .ready(ready), .valid(valid), .y(y),
      .y_out(y_out), .y_strobe(y_strobe), .error(error)
   );

   // Downstream block: y = a*x*x + b*x + c, three cycles after enable, busy keeps ready low.
   always @(posedge clock) begin
      valid <= 1'b0;
      if (enable && !busy) begin
         busy        <= 1'b1;
         cnt         <= 3;
         model_ready <= 1'b0;
         ry          <= a * x * x + b * x + c;
      end else if (busy) begin
         cnt <= cnt - 1;
         if (cnt == 1) begin
            busy        <= 1'b0;
            model_ready <= 1'b1;
            if (!mute) begin
               valid <= 1'b1;
               y     <= ry;
            end
         end
      end
   end

   logic        prev_en = 1'b0;
   int          en_count = 0;
   int          b2b = 0;
   logic [55:0] en_ops [$];
   logic signed [15:0] ys [$];

   always @(negedge clock) begin
      prev_en <= enable;
      if (enable) begin
         en_count <= en_count + 1;
         en_ops.push_back({x, a, b, c});
         if (prev_en)
            b2b <= b2b + 1;
      end
      if (y_strobe) begin
         ys.push_back(y_out);
         $display("result %0d: y_out=%0d", ys.size(), y_out);
      end
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_push(input vec_t v);
      push = 1'b1;
      x_in = v.x;
      a_in = v.a;
      b_in = v.b;
      c_in = v.c;
      $display("push x=%0d a=%0d b=%0d c=%0d", v.x, v.a, v.b, v.c);
      tick();
      push = 1'b0;
   endtask

   task automatic wait_results(input int n, input int limit);
      int k = 0;
      while (ys.size() < n && k < limit) begin
         tick();
         k++;
      end
      if (ys.size() < n)
         check("wait_results_bound", ys.size(), n);
   endtask

   task automatic wait_enable(input int limit);
      int k = 0;
      while (!enable && k < limit) begin
         tick();
         k++;
      end
      check("enable_seen", enable, 1);
   endtask

   initial begin
      int base_en;
      int k;
      vecs[0] = '{x: 2,  a: 1, b: 2, c: 3,  y: 11};
      vecs[1] = '{x: 1,  a: 1, b: 1, c: 1,  y: 3};
      vecs[2] = '{x: 2,  a: 0, b: 0, c: 5,  y: 5};
      vecs[3] = '{x: -1, a: 2, b: 0, c: 0,  y: 2};
      vecs[4] = '{x: 3,  a: 1, b: 0, c: -9, y: 0};

      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_overflow", overflow, 0);
      check("rst_error", error, 0);
      check("rst_enable", enable, 0);
      check("rst_y_strobe", y_strobe, 0);
      check("rst_y_out", y_out, 0);
      check("rst_x", x, 0);
      check("rst_a", a, 0);
      check("rst_b", b, 0);
      check("rst_c", c, 0);

      // Fill the queue with the downstream held off, then push one more into a full queue.
      hold = 1'b1;
      for (int i = 1; i <= 4; i++)
         do_push(vecs[i]);
      check("burst_full", full, 1);
      check("burst_empty", empty, 0);
      check("burst_overflow_clear", overflow, 0);
      do_push(vecs[0]);
      check("drop_overflow", overflow, 1);
      check("drop_full", full, 1);
      check("held_no_enable", en_count, 0);
      hold = 1'b0;
      wait_results(4, 200);
      repeat (30) tick();
      check("only_four_results", ys.size(), 4);
      for (int i = 0; i < 4 && i < ys.size() && i < en_ops.size(); i++) begin
         check($sformatf("burst_y_%0d", i), ys[i], vecs[i+1].y);
         check($sformatf("burst_ops_%0d", i), en_ops[i],
               {vecs[i+1].x, vecs[i+1].a, vecs[i+1].b, vecs[i+1].c});
      end
      check("burst_end_empty", empty, 1);
      check("burst_end_full", full, 0);

      do_push(vecs[0]);
      wait_results(5, 100);
      check("single_y_out", y_out, 11);
      check("single_enables", en_count, 5);
      if (ys.size() >= 5 && en_ops.size() >= 5) begin
         check("single_y", ys[4], vecs[0].y);
         check("single_ops", en_ops[4], {vecs[0].x, vecs[0].a, vecs[0].b, vecs[0].c});
      end
      check("no_back_to_back", b2b, 0);
      check("sticky_overflow", overflow, 1);

      // Reset while the downstream is computing; its late valid must be ignored.
      base_en = en_count;
      do_push(vecs[0]);
      wait_enable(50);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_enable", enable, 0);
      check("midrst_y_out", y_out, 0);
      check("midrst_x", x, 0);
      check("midrst_a", a, 0);
      check("midrst_c", c, 0);
      check("midrst_overflow", overflow, 0);
      check("midrst_empty", empty, 1);
      check("midrst_y_strobe", y_strobe, 0);
      check("midrst_error", error, 0);
      repeat (20) tick();
      check("midrst_no_late_strobe", ys.size(), 5);
      check("midrst_one_enable", en_count, base_en + 1);

      // Downstream never answers.
      mute = 1'b1;
      base_en = en_count;
      do_push(vecs[1]);
      wait_enable(50);
      k = 0;
      while (!error && k < 40) begin
         tick();
         k++;
      end
`ifdef OPERAND_DISPATCHER_TIMEOUT_EN
      check("timeout_error", error, 1);
      check("timeout_latency_ok", (k >= 9 && k <= 13), 1);
      check("timeout_y_out_kept", y_out, 0);
      check("timeout_no_strobe", ys.size(), 5);
      do_push(vecs[2]);
      wait_enable(30);
      check("timeout_back_idle", en_count >= base_en + 2, 1);
`else
      check("no_timeout_error", error, 0);
      check("no_timeout_single_enable", en_count, base_en + 1);
      check("no_timeout_no_strobe", ys.size(), 5);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
